// File: rtl/m72_sound_latch_if.sv
// Z80-side bus of the M72 sound command latch: Z80 address/strobes in,
// data-in mux contribution and INT out.
interface m72_sound_latch_if;
  logic [7:0] z80_addr;
  logic       z80_iorq_n;
  logic       z80_rd_n;
  logic       z80_wr_n;
  logic       z80_m1_n;
  logic [7:0] z80_dout;
  logic [7:0] z80_din;
  logic       z80_din_valid;
  logic       z80_int_n;

  modport master (
    output z80_addr, z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n, z80_dout,
    input  z80_din, z80_din_valid, z80_int_n
  );

  modport slave (
    input  z80_addr, z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n, z80_dout,
    output z80_din, z80_din_valid, z80_int_n
  );
endinterface

// File: rtl/m72_sound_latch.sv
// Main-CPU to Z80 sound command latch with mode-0 RST vector generation
// merging the latch request and the YM2151 IRQ.
module m72_sound_latch (
  input  logic                  CLK_32M,
  input  logic                  reset_n,
  input  logic                  ce_z80,
  input  logic                  SND,
  input  logic                  IO_A0,
  input  logic [7:0]            IO_DIN,
  input  logic                  ym_irq_n,
  m72_sound_latch_if.slave      z80,
  output logic                  overrun,
  output logic [7:0]            cmd_count
);
  localparam logic [7:0] LATCH_PORT = 8'h02;
  localparam logic [7:0] ACK_PORT   = 8'h06;
  localparam logic [7:0] RST_LATCH  = 8'hDF;
  localparam logic [7:0] RST_YM     = 8'hEF;

  typedef enum logic [1:0] {IDLE, RD_LATCH, INTACK, WR_ACK} state_t;

  state_t     state;
  logic       snd_req, snd_prev, load;
  logic [7:0] latch, latch_next, vector;
  logic       latch_pend;
  logic       ym_sync1, ym_sync2, ym_pend;
  logic       io_rd, io_wr, int_ack;
  logic       io_rd_prev, io_wr_prev, int_ack_prev;
  logic       ack_start, rd_hit, wr_hit, ack_clear;

  assign snd_req    = SND & ~IO_A0;
  assign load       = snd_req & ~snd_prev;
  assign latch_next = load ? IO_DIN : latch;

  assign ym_pend = ~ym_sync2;
  assign vector  = 8'hFF & (latch_pend ? RST_LATCH : 8'hFF) & (ym_pend ? RST_YM : 8'hFF);

  assign io_rd   = ~z80.z80_iorq_n & ~z80.z80_rd_n & z80.z80_m1_n;
  assign io_wr   = ~z80.z80_iorq_n & ~z80.z80_wr_n;
  assign int_ack = ~z80.z80_iorq_n & ~z80.z80_m1_n;

  // Accesses start on the asserting edge of each qualified strobe, as seen on ce_z80
  assign ack_start = ce_z80 & int_ack & ~int_ack_prev;
  assign rd_hit    = ce_z80 & io_rd & ~io_rd_prev & (z80.z80_addr == LATCH_PORT);
  assign wr_hit    = ce_z80 & io_wr & ~io_wr_prev & (z80.z80_addr == ACK_PORT);
  assign ack_clear = (state == IDLE) & ~ack_start & ~rd_hit & wr_hit;

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      snd_prev   <= 1'b0;
      latch      <= 8'h00;
      latch_pend <= 1'b0;
      overrun    <= 1'b0;
      cmd_count  <= 8'h00;
    end else begin
      snd_prev <= snd_req;
      latch    <= latch_next;
      // A fresh load outranks a coincident acknowledge
      if (load) begin
        latch_pend <= 1'b1;
        cmd_count  <= cmd_count + 8'd1;
        if (latch_pend && !ack_clear)
          overrun <= 1'b1;
      end else if (ack_clear) begin
        latch_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      ym_sync1      <= 1'b1;
      ym_sync2      <= 1'b1;
      z80.z80_int_n <= 1'b1;
    end else begin
      ym_sync1      <= ym_irq_n;
      ym_sync2      <= ym_sync1;
      z80.z80_int_n <= ~(latch_pend | ym_pend);
    end
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      io_rd_prev        <= 1'b0;
      io_wr_prev        <= 1'b0;
      int_ack_prev      <= 1'b0;
      z80.z80_din       <= 8'hFF;
      z80.z80_din_valid <= 1'b0;
    end else begin
      if (ce_z80) begin
        io_rd_prev   <= io_rd;
        io_wr_prev   <= io_wr;
        int_ack_prev <= int_ack;
      end
      case (state)
        IDLE: begin
          if (ack_start) begin
            state             <= INTACK;
            z80.z80_din       <= vector;
            z80.z80_din_valid <= 1'b1;
          end else if (rd_hit) begin
            state             <= RD_LATCH;
            z80.z80_din       <= latch_next;
            z80.z80_din_valid <= 1'b1;
          end else if (wr_hit) begin
            state <= WR_ACK;
          end
        end
        RD_LATCH: begin
          if (ce_z80 && z80.z80_iorq_n) begin
            state             <= IDLE;
            z80.z80_din       <= 8'hFF;
            z80.z80_din_valid <= 1'b0;
          end else begin
            // Track a command arriving while the Z80 is still reading
            z80.z80_din <= latch_next;
          end
        end
        INTACK: begin
          if (ce_z80 && z80.z80_iorq_n) begin
            state             <= IDLE;
            z80.z80_din       <= 8'hFF;
            z80.z80_din_valid <= 1'b0;
          end
        end
        WR_ACK: begin
          if (ce_z80 && z80.z80_iorq_n)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m72_sound_latch.sv
// Bench for m72_sound_latch: directed main-CPU/Z80 traffic, a transaction-level
// reference model compared every cycle, plus literal expectations.
module tb_m72_sound_latch;
  logic       CLK_32M = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce_z80 = 1'b0;
  logic       SND = 1'b0;
  logic       IO_A0 = 1'b0;
  logic [7:0] IO_DIN = 8'h00;
  logic       ym_irq_n = 1'b1;
  logic       overrun;
  logic [7:0] cmd_count;

  m72_sound_latch_if bus();

  m72_sound_latch dut (
    .CLK_32M   (CLK_32M),
    .reset_n   (reset_n),
    .ce_z80    (ce_z80),
    .SND       (SND),
    .IO_A0     (IO_A0),
    .IO_DIN    (IO_DIN),
    .ym_irq_n  (ym_irq_n),
    .z80       (bus),
    .overrun   (overrun),
    .cmd_count (cmd_count)
  );

  always #5 CLK_32M = ~CLK_32M;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit ce_en = 1'b1;
  bit ce_force = 1'b0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: tracks the pending command, the Z80 transaction in
  // progress and the delayed IRQ view, and predicts the visible outputs.
  bit         m_sndp = 0, m_pend = 0, m_ovr = 0;
  logic [7:0] m_latch = 8'h00, m_cnt = 8'h00, m_vec = 8'hFF;
  bit         m_ym1 = 1, m_ympend = 0;
  int         m_txn = 0;   // 0 none, 1 latch read, 2 int ack, 3 ack write
  bit         m_prd = 0, m_pwr = 0, m_pia = 0;
  logic [7:0] e_din = 8'hFF;
  bit         e_valid = 0, e_int_n = 1;
  bit         s_req, s_load, s_ack, s_rd, s_wr, s_ia;

  initial forever begin
    @(posedge CLK_32M or negedge reset_n);
    if (!reset_n) begin
      m_sndp = 0; m_pend = 0; m_ovr = 0; m_latch = 8'h00; m_cnt = 8'h00;
      m_ym1 = 1; m_ympend = 0; m_txn = 0; m_prd = 0; m_pwr = 0; m_pia = 0;
      e_din = 8'hFF; e_valid = 0; e_int_n = 1;
    end else begin
      s_req  = SND && !IO_A0;
      s_load = s_req && !m_sndp;
      m_sndp = s_req;
      s_ack  = 0;
      if (ce_z80) begin
        s_rd = !bus.z80_iorq_n && !bus.z80_rd_n && bus.z80_m1_n;
        s_wr = !bus.z80_iorq_n && !bus.z80_wr_n;
        s_ia = !bus.z80_iorq_n && !bus.z80_m1_n;
        if (m_txn == 0) begin
          if (s_ia && !m_pia) begin
            m_txn = 2;
            m_vec = 8'hFF;
            if (m_pend)   m_vec = m_vec - 8'h20;   // RST 18h
            if (m_ympend) m_vec = m_vec - 8'h10;   // RST 28h
          end else if (s_rd && !m_prd && bus.z80_addr == 8'h02) begin
            m_txn = 1;
          end else if (s_wr && !m_pwr && bus.z80_addr == 8'h06) begin
            m_txn = 3;
            s_ack = 1;
          end
        end else if (bus.z80_iorq_n) begin
          m_txn = 0;
        end
        m_prd = s_rd; m_pwr = s_wr; m_pia = s_ia;
      end
      e_int_n = !(m_pend || m_ympend);
      if (s_load) begin
        if (m_pend && !s_ack) m_ovr = 1;
        m_pend = 1;
        m_latch = IO_DIN;
        m_cnt = m_cnt + 8'd1;
      end else if (s_ack) begin
        m_pend = 0;
      end
      m_ympend = !m_ym1;
      m_ym1 = ym_irq_n;
      e_valid = (m_txn == 1) || (m_txn == 2);
      e_din = (m_txn == 1) ? m_latch : (m_txn == 2) ? m_vec : 8'hFF;
    end
  end

  initial forever begin
    @(negedge CLK_32M);
    if (cmp_en) begin
      chk("cyc_din", bus.z80_din, e_din);
      chk("cyc_valid", bus.z80_din_valid, e_valid);
      chk("cyc_int_n", bus.z80_int_n, e_int_n);
      chk("cyc_overrun", overrun, m_ovr);
      chk("cyc_cmd_count", cmd_count, m_cnt);
    end
  end

  task automatic tick();
    @(posedge CLK_32M);
    #2;
    cyc++;
    ce_z80 = ce_en ? (cyc % 4 == 0) : ce_force;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic snd_write(input logic [7:0] d, input logic a0, input int hold);
    IO_DIN = d; IO_A0 = a0; SND = 1'b1;
    ticks(hold);
    SND = 1'b0; IO_A0 = 1'b0;
    ticks(2);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (bus.z80_din_valid !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for z80_din_valid", name);
    end
  endtask

  task automatic bus_idle();
    bus.z80_iorq_n = 1'b1; bus.z80_rd_n = 1'b1; bus.z80_wr_n = 1'b1; bus.z80_m1_n = 1'b1;
  endtask

  task automatic z80_intack(input string name, input logic [7:0] req);
    bus.z80_m1_n = 1'b0; bus.z80_iorq_n = 1'b0;
    wait_valid(name);
    tick();
    chk(name, bus.z80_din, req);
    bus_idle();
    ticks(6);
    chk({name, "_valid_drop"}, bus.z80_din_valid, 1'b0);
  endtask

  task automatic z80_read(input string name, input logic [7:0] addr, input logic [7:0] req);
    bus.z80_addr = addr; bus.z80_iorq_n = 1'b0; bus.z80_rd_n = 1'b0;
    wait_valid(name);
    chk(name, bus.z80_din, req);
    bus_idle();
    ticks(6);
  endtask

  task automatic z80_write(input logic [7:0] addr, input logic [7:0] d);
    bus.z80_addr = addr; bus.z80_dout = d; bus.z80_iorq_n = 1'b0; bus.z80_wr_n = 1'b0;
    ticks(6);
    bus_idle();
    ticks(6);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    ticks(2);
  endtask

  initial begin
    bus_idle();
    bus.z80_addr = 8'h00;
    bus.z80_dout = 8'h00;
    ticks(3);
    cmp_en = 1'b1;
    chk("rst_din", bus.z80_din, 8'hFF);
    chk("rst_valid", bus.z80_din_valid, 1'b0);
    chk("rst_int_n", bus.z80_int_n, 1'b1);
    chk("rst_cmd_count", cmd_count, 8'h00);
    reset_n = 1'b1;
    ticks(3);

    // Command delivery
    IO_DIN = 8'h3C; IO_A0 = 1'b0; SND = 1'b1;
    tick();
    chk("cmd_int_n_1cyc", bus.z80_int_n, 1'b1);
    tick();
    chk("cmd_int_n_2cyc", bus.z80_int_n, 1'b0);
    ticks(2);
    SND = 1'b0;
    ticks(2);
    chk("cmd_count_1", cmd_count, 8'd1);
    z80_intack("intack_latch", 8'hDF);
    z80_read("read_3c", 8'h02, 8'h3C);
    z80_write(8'h06, 8'hA5);
    chk("ack_int_n", bus.z80_int_n, 1'b1);

    // Both sources pending
    ym_irq_n = 1'b0;
    snd_write(8'hAA, 1'b0, 2);
    ticks(4);
    z80_intack("intack_both", 8'hCF);
    z80_write(8'h06, 8'h00);
    chk("ym_int_n_held", bus.z80_int_n, 1'b0);
    z80_intack("intack_ym", 8'hEF);
    ym_irq_n = 1'b1;
    ticks(5);
    chk("ym_release_int_n", bus.z80_int_n, 1'b1);

    // Odd address ignored
    snd_write(8'h55, 1'b1, 3);
    ticks(3);
    chk("odd_cmd_count", cmd_count, 8'd2);
    chk("odd_int_n", bus.z80_int_n, 1'b1);
    z80_read("odd_latch", 8'h02, 8'hAA);

    // Overrun
    snd_write(8'h01, 1'b0, 2);
    snd_write(8'h02, 1'b0, 2);
    chk("overrun_set", overrun, 1'b1);
    z80_read("overrun_latch", 8'h02, 8'h02);

    // Load coincident with ack-port clear
    do_reset();
    snd_write(8'h11, 1'b0, 2);
    ce_en = 1'b0; ce_force = 1'b0;
    tick();
    bus.z80_addr = 8'h06; bus.z80_iorq_n = 1'b0; bus.z80_wr_n = 1'b0;
    tick();
    IO_DIN = 8'h77; SND = 1'b1; ce_z80 = 1'b1;
    tick();
    SND = 1'b0;
    tick();
    bus_idle();
    ce_force = 1'b1;
    tick();
    ce_force = 1'b0; ce_en = 1'b1;
    ticks(6);
    chk("coinc_overrun", overrun, 1'b0);
    chk("coinc_int_n", bus.z80_int_n, 1'b0);
    z80_read("coinc_latch", 8'h02, 8'h77);

    // Clock enable held low
    ce_en = 1'b0; ce_force = 1'b0;
    tick();
    bus.z80_addr = 8'h02; bus.z80_iorq_n = 1'b0; bus.z80_rd_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("noce_valid", bus.z80_din_valid, 1'b0);
    end
    bus_idle();
    tick();
    ce_en = 1'b1;
    ticks(6);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      IO_DIN = i[7:0]; SND = 1'b1;
      tick();
      SND = 1'b0;
      tick();
    end
    ticks(2);
    chk("wrap_cmd_count", cmd_count, 8'h00);
    chk("wrap_overrun", overrun, 1'b1);

    // Reset mid-INTACK
    bus.z80_m1_n = 1'b0; bus.z80_iorq_n = 1'b0;
    wait_valid("midrst_enter");
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_din", bus.z80_din, 8'hFF);
    chk("midrst_valid", bus.z80_din_valid, 1'b0);
    chk("midrst_int_n", bus.z80_int_n, 1'b1);
    chk("midrst_overrun", overrun, 1'b0);
    chk("midrst_cmd_count", cmd_count, 8'h00);
    bus_idle();
    ticks(2);
    reset_n = 1'b1;
    ticks(3);
    z80_read("midrst_idle_read", 8'h02, 8'h00);

    ticks(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
